// File: rtl/ahb_lsu_master_if.sv
// Bus bundle between the RV32 execute stage, the AHB-Lite fabric and the load unit
// as seen by the load/store master.
interface ahb_lsu_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Execute-stage request side
  logic              mem_req_in;
  logic              mem_we_in;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic [1:0]        size_in;
  logic              unsigned_in;
  logic              ready_out;
  logic              done_out;
  logic              err_out;
  logic              misaligned_out;

  // AHB-Lite master side
  logic [ADDR_W-1:0] haddr_out;
  logic [1:0]        htrans_out;
  logic              hwrite_out;
  logic [2:0]        hsize_out;
  logic [2:0]        hburst_out;
  logic [DATA_W-1:0] hwdata_out;
  logic              hready_in;
  logic              hresp_in;
  logic [DATA_W-1:0] hrdata_in;

  // Load-unit side, aligned with the data phase
  logic [1:0]        lu_size_out;
  logic              lu_unsigned_out;
  logic [1:0]        lu_offset_out;
  logic [DATA_W-1:0] lu_data_out;
  logic              lu_resp_out;

  modport master (
    input  mem_req_in, mem_we_in, addr_in, wdata_in, size_in, unsigned_in,
    output ready_out, done_out, err_out, misaligned_out,
    output haddr_out, htrans_out, hwrite_out, hsize_out, hburst_out, hwdata_out,
    input  hready_in, hresp_in, hrdata_in,
    output lu_size_out, lu_unsigned_out, lu_offset_out, lu_data_out, lu_resp_out
  );

  modport slave (
    output mem_req_in, mem_we_in, addr_in, wdata_in, size_in, unsigned_in,
    input  ready_out, done_out, err_out, misaligned_out,
    input  haddr_out, htrans_out, hwrite_out, hsize_out, hburst_out, hwdata_out,
    output hready_in, hresp_in, hrdata_in,
    input  lu_size_out, lu_unsigned_out, lu_offset_out, lu_data_out, lu_resp_out
  );
endinterface

// File: rtl/ahb_lsu_master.sv
// AHB-Lite master for the RV32 load/store path: single NONSEQ transfers with pipelined
// address (_p0) and data (_p1) phases, store lane replication, error abort and misalign traps.
module ahb_lsu_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  ahb_lsu_master_if.master   bus
);

  typedef enum logic [1:0] {
    S_RUN,
    S_ERR,
    S_ABORT
  } state_t;

  state_t            state;
  logic              abort_pend;

  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              we_p0;
  logic [1:0]        size_p0;
  logic              uns_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              vld_p1;
  logic [1:0]        size_p1;
  logic              uns_p1;
  logic [1:0]        off_p1;
  logic [DATA_W-1:0] hwdata_p1;

  logic              done_r;
  logic              err_r;
  logic              mis_r;

  logic [1:0]        req_size;
  logic              req_mis;
  logic              err_busy;
  logic              ready;
  logic              acc_ok;
  logic              acc_mis;
  logic              dp_fin;
  logic              cancel;

  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? 2'b10 : s;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] s, input logic [1:0] a);
    case (s)
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_replicate(input logic [1:0] s,
                                                       input logic [DATA_W-1:0] d);
    case (s)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  always_comb begin
    req_size = norm_size(bus.size_in);
    req_mis  = is_misaligned(req_size, bus.addr_in[1:0]);
    // The first ERROR cycle already blocks acceptance, before the FSM has moved.
    err_busy = (state != S_RUN) || (vld_p1 && bus.hresp_in);
    ready    = !err_busy && (req_mis ? (!vld_p0 && !vld_p1) : (!vld_p0 || bus.hready_in));
    acc_ok   = bus.mem_req_in && ready && !req_mis;
    acc_mis  = bus.mem_req_in && ready && req_mis;
    dp_fin   = vld_p1 && bus.hready_in;
    cancel   = (state == S_RUN) && vld_p1 && bus.hresp_in && !bus.hready_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= S_RUN;
      abort_pend <= 1'b0;
      vld_p0     <= 1'b0;
      addr_p0    <= '0;
      we_p0      <= 1'b0;
      size_p0    <= 2'b00;
      uns_p0     <= 1'b0;
      wdata_p0   <= '0;
      vld_p1     <= 1'b0;
      size_p1    <= 2'b00;
      uns_p1     <= 1'b0;
      off_p1     <= 2'b00;
      hwdata_p1  <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      mis_r      <= 1'b0;
    end else begin
      done_r <= dp_fin || acc_mis || (state == S_ABORT);
      err_r  <= (dp_fin && bus.hresp_in) || (state == S_ABORT);
      mis_r  <= acc_mis;

      // p0 -> p1: data phase advances only on HREADY
      if (bus.hready_in) begin
        vld_p1 <= vld_p0;
        if (vld_p0) begin
          size_p1   <= size_p0;
          uns_p1    <= uns_p0;
          off_p1    <= addr_p0[1:0];
          hwdata_p1 <= lane_replicate(size_p0, wdata_p0);
        end
      end

      // request -> p0: address phase
      if (cancel) begin
        vld_p0 <= 1'b0;
      end else if (acc_ok) begin
        vld_p0   <= 1'b1;
        addr_p0  <= bus.addr_in;
        we_p0    <= bus.mem_we_in;
        size_p0  <= req_size;
        uns_p0   <= bus.unsigned_in;
        wdata_p0 <= bus.wdata_in;
      end else if (bus.hready_in) begin
        vld_p0 <= 1'b0;
      end

      case (state)
        S_RUN: begin
          if (cancel) begin
            state      <= S_ERR;
            abort_pend <= vld_p0;
          end
        end
        S_ERR: begin
          if (bus.hready_in) state <= abort_pend ? S_ABORT : S_RUN;
        end
        S_ABORT: begin
          state      <= S_RUN;
          abort_pend <= 1'b0;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign bus.ready_out       = ready;
  assign bus.done_out        = done_r;
  assign bus.err_out         = err_r;
  assign bus.misaligned_out  = mis_r;
  assign bus.haddr_out       = addr_p0;
  assign bus.htrans_out      = vld_p0 ? 2'b10 : 2'b00;
  assign bus.hwrite_out      = we_p0;
  assign bus.hsize_out       = {1'b0, size_p0};
  assign bus.hburst_out      = 3'b000;
  assign bus.hwdata_out      = hwdata_p1;
  assign bus.lu_size_out     = size_p1;
  assign bus.lu_unsigned_out = uns_p1;
  assign bus.lu_offset_out   = off_p1;
  assign bus.lu_data_out     = bus.hrdata_in;
  assign bus.lu_resp_out     = bus.hresp_in;

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Directed bench for ahb_lsu_master; completions are checked against a scoreboard of
// expected (err, misaligned, cycle) entries pushed when each request is accepted.
module tb_ahb_lsu_master;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    logic err;
    logic mis;
    int   due;
  } exp_t;

  exp_t sb[$];

  ahb_lsu_master_if bus ();

  ahb_lsu_master dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic push(input logic err, input logic mis, input int due);
    exp_t e;
    e.err = err;
    e.mis = mis;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic u);
    bus.mem_req_in  = 1'b1;
    bus.mem_we_in   = we;
    bus.addr_in     = a;
    bus.wdata_in    = d;
    bus.size_in     = sz;
    bus.unsigned_in = u;
  endtask

  // Completion monitor: every done_out pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_err", {31'd0, bus.err_out}, {31'd0, e.err});
        chk("done_mis", {31'd0, bus.misaligned_out}, {31'd0, e.mis});
        chk("done_cycle", cyc, e.due);
      end
    end else if (bus.err_out === 1'b1 || bus.misaligned_out === 1'b1) begin
      chk("qualifier_without_done", 32'd1, 32'd0);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.mem_req_in  = 1'b0;
    bus.mem_we_in   = 1'b0;
    bus.addr_in     = '0;
    bus.wdata_in    = '0;
    bus.size_in     = 2'b10;
    bus.unsigned_in = 1'b0;
    bus.hready_in   = 1'b1;
    bus.hresp_in    = 1'b0;
    bus.hrdata_in   = '0;

    // reset state
    repeat (2) tick;
    #1;
    chk("rst_htrans", {30'd0, bus.htrans_out}, 32'd0);
    chk("rst_haddr", bus.haddr_out, 32'd0);
    chk("rst_hwdata", bus.hwdata_out, 32'd0);
    chk("rst_done", {31'd0, bus.done_out}, 32'd0);
    chk("rst_err", {31'd0, bus.err_out}, 32'd0);
    chk("rst_mis", {31'd0, bus.misaligned_out}, 32'd0);
    chk("rst_lu_size", {30'd0, bus.lu_size_out}, 32'd0);
    chk("rst_hburst", {29'd0, bus.hburst_out}, 32'd0);
    rst = 1'b0;

    // load word 0x100, zero wait states
    tick; req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    #1 chk("t1_ready", {31'd0, bus.ready_out}, 32'd1);
    push(1'b0, 1'b0, cyc + 3);
    tick; bus.mem_req_in = 1'b0;
    #1 chk("t1_htrans", {30'd0, bus.htrans_out}, 32'h2);
    chk("t1_hsize", {29'd0, bus.hsize_out}, 32'h2);
    chk("t1_haddr", bus.haddr_out, 32'h100);
    chk("t1_hwrite", {31'd0, bus.hwrite_out}, 32'd0);
    tick; bus.hrdata_in = 32'hDEADBEEF;
    #1 chk("t1_lu_data", bus.lu_data_out, 32'hDEADBEEF);
    chk("t1_lu_offset", {30'd0, bus.lu_offset_out}, 32'd0);
    chk("t1_lu_size", {30'd0, bus.lu_size_out}, 32'h2);
    chk("t1_htrans_idle", {30'd0, bus.htrans_out}, 32'd0);
    tick;
    #1 chk("t1_done", {31'd0, bus.done_out}, 32'd1);

    // store byte 0xA5 at 0x203
    tick; req(1'b1, 32'h203, 32'h000000A5, 2'b00, 1'b0);
    #1 chk("t2_ready", {31'd0, bus.ready_out}, 32'd1);
    push(1'b0, 1'b0, cyc + 3);
    tick; bus.mem_req_in = 1'b0;
    #1 chk("t2_hsize", {29'd0, bus.hsize_out}, 32'd0);
    chk("t2_haddr", bus.haddr_out, 32'h203);
    chk("t2_hwrite", {31'd0, bus.hwrite_out}, 32'd1);
    tick;
    #1 chk("t2_hwdata", bus.hwdata_out, 32'hA5A5A5A5);
    tick;

    // load half 0x302 with 3 wait states, word load 0x400 queued behind it
    tick; req(1'b0, 32'h302, 32'h0000BEEF, 2'b01, 1'b1);
    #1 chk("t3_ready_a", {31'd0, bus.ready_out}, 32'd1);
    push(1'b0, 1'b0, cyc + 6);
    tick; req(1'b0, 32'h400, 32'h0, 2'b10, 1'b0);
    #1 chk("t3_ready_b", {31'd0, bus.ready_out}, 32'd1);
    chk("t3_haddr_a", bus.haddr_out, 32'h302);
    chk("t3_hsize_a", {29'd0, bus.hsize_out}, 32'h1);
    push(1'b0, 1'b0, cyc + 6);
    tick; bus.mem_req_in = 1'b0; bus.hready_in = 1'b0;
    #1 chk("t3_ready_stall", {31'd0, bus.ready_out}, 32'd0);
    chk("t3_haddr_b", bus.haddr_out, 32'h400);
    chk("t3_lu_offset", {30'd0, bus.lu_offset_out}, 32'h2);
    chk("t3_lu_unsigned", {31'd0, bus.lu_unsigned_out}, 32'd1);
    chk("t3_hwdata", bus.hwdata_out, 32'hBEEFBEEF);
    tick;
    #1 chk("t3_haddr_hold", bus.haddr_out, 32'h400);
    chk("t3_htrans_hold", {30'd0, bus.htrans_out}, 32'h2);
    chk("t3_hsize_hold", {29'd0, bus.hsize_out}, 32'h2);
    tick;
    #1 chk("t3_hwdata_hold", bus.hwdata_out, 32'hBEEFBEEF);
    chk("t3_lu_size_hold", {30'd0, bus.lu_size_out}, 32'h1);
    chk("t3_no_early_done", {31'd0, bus.done_out}, 32'd0);
    tick; bus.hready_in = 1'b1; bus.hrdata_in = 32'h1234ABCD;
    #1 chk("t3_lu_data", bus.lu_data_out, 32'h1234ABCD);
    tick;
    #1 chk("t3_lu_offset_b", {30'd0, bus.lu_offset_out}, 32'd0);
    chk("t3_lu_size_b", {30'd0, bus.lu_size_out}, 32'h2);
    chk("t3_htrans_idle", {30'd0, bus.htrans_out}, 32'd0);
    tick; tick;

    // back-to-back loads 0x0, 0x4, 0x8
    tick; req(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    #1 chk("t4_ready0", {31'd0, bus.ready_out}, 32'd1);
    push(1'b0, 1'b0, cyc + 3);
    tick; req(1'b0, 32'h4, 32'h0, 2'b10, 1'b0);
    #1 chk("t4_ready1", {31'd0, bus.ready_out}, 32'd1);
    chk("t4_haddr0", bus.haddr_out, 32'h0);
    chk("t4_htrans0", {30'd0, bus.htrans_out}, 32'h2);
    push(1'b0, 1'b0, cyc + 3);
    tick; req(1'b0, 32'h8, 32'h0, 2'b10, 1'b0);
    #1 chk("t4_ready2", {31'd0, bus.ready_out}, 32'd1);
    chk("t4_haddr1", bus.haddr_out, 32'h4);
    chk("t4_htrans1", {30'd0, bus.htrans_out}, 32'h2);
    push(1'b0, 1'b0, cyc + 3);
    tick; bus.mem_req_in = 1'b0;
    #1 chk("t4_haddr2", bus.haddr_out, 32'h8);
    chk("t4_htrans2", {30'd0, bus.htrans_out}, 32'h2);
    repeat (3) tick;

    // ERROR on load 0x10 while store 0x14 sits in the address phase
    tick; req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    push(1'b1, 1'b0, cyc + 4);
    tick; req(1'b1, 32'h14, 32'h55, 2'b10, 1'b0);
    #1 chk("t5_ready_b", {31'd0, bus.ready_out}, 32'd1);
    push(1'b1, 1'b0, cyc + 4);
    tick; bus.mem_req_in = 1'b0; bus.hresp_in = 1'b1; bus.hready_in = 1'b0;
    #1 chk("t5_ready_err1", {31'd0, bus.ready_out}, 32'd0);
    chk("t5_htrans_err1", {30'd0, bus.htrans_out}, 32'h2);
    chk("t5_haddr_err1", bus.haddr_out, 32'h14);
    chk("t5_lu_resp", {31'd0, bus.lu_resp_out}, 32'd1);
    tick; bus.hready_in = 1'b1;
    #1 chk("t5_htrans_err2", {30'd0, bus.htrans_out}, 32'd0);
    chk("t5_ready_err2", {31'd0, bus.ready_out}, 32'd0);
    chk("t5_done_err2", {31'd0, bus.done_out}, 32'd0);
    tick; bus.hresp_in = 1'b0;
    #1 chk("t5_ready_abort", {31'd0, bus.ready_out}, 32'd0);
    tick;
    #1 chk("t5_ready_resume", {31'd0, bus.ready_out}, 32'd1);
    tick;

    // misaligned word at 0x102 on an idle pipeline
    tick; req(1'b0, 32'h102, 32'h0, 2'b10, 1'b0);
    #1 chk("t6_ready_mis", {31'd0, bus.ready_out}, 32'd1);
    push(1'b0, 1'b1, cyc + 1);
    tick; bus.mem_req_in = 1'b0;
    #1 chk("t6_no_nonseq", {30'd0, bus.htrans_out}, 32'd0);
    tick;
    // misaligned half waits for the pipeline to drain
    tick; req(1'b0, 32'h200, 32'h0, 2'b10, 1'b0);
    push(1'b0, 1'b0, cyc + 3);
    tick; req(1'b0, 32'h201, 32'h0, 2'b01, 1'b0);
    #1 chk("t6_mis_blocked_ap", {31'd0, bus.ready_out}, 32'd0);
    tick;
    #1 chk("t6_mis_blocked_dp", {31'd0, bus.ready_out}, 32'd0);
    tick;
    #1 chk("t6_mis_drained", {31'd0, bus.ready_out}, 32'd1);
    push(1'b0, 1'b1, cyc + 1);
    tick; bus.mem_req_in = 1'b0;
    #1 chk("t6_no_nonseq_b", {30'd0, bus.htrans_out}, 32'd0);
    tick;

    // reset in the middle of a wait state
    tick; req(1'b1, 32'h500, 32'h77, 2'b00, 1'b0);
    tick; bus.mem_req_in = 1'b0;
    tick; bus.hready_in = 1'b0;
    tick; rst = 1'b1;
    tick; rst = 1'b0; bus.hready_in = 1'b1;
    #1 chk("t7_htrans", {30'd0, bus.htrans_out}, 32'd0);
    chk("t7_done", {31'd0, bus.done_out}, 32'd0);
    chk("t7_err", {31'd0, bus.err_out}, 32'd0);
    chk("t7_mis", {31'd0, bus.misaligned_out}, 32'd0);
    chk("t7_hwdata", bus.hwdata_out, 32'd0);
    chk("t7_haddr", bus.haddr_out, 32'd0);
    chk("t7_lu_size", {30'd0, bus.lu_size_out}, 32'd0);
    chk("t7_ready", {31'd0, bus.ready_out}, 32'd1);

    repeat (3) tick;
    #1 chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lsu_master.md
Name: ahb_lsu_master

Overview:
- AHB-Lite master front end of the RV32 load/store path.
- Accepts one load/store request per cycle from the execute stage and issues single transfers with pipelined address and data phases.
- Replicates store data across byte lanes and handles wait states, ERROR responses and misalignment traps.
- Carries load size, signedness and address offset into the data phase so the downstream load unit receives them aligned with HRDATA.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (only 32 is supported)

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- mem_req_in  input  1  request valid
- mem_we_in  input  1  1 = store, 0 = load
- addr_in  input  32  byte address
- wdata_in  input  32  store data, right-justified
- size_in  input  2  00 byte, 01 half, 10 word (11 treated as word)
- unsigned_in  input  1  load zero-extend flag
- ready_out  output  1  request accepted at this edge if mem_req_in=1
- done_out  output  1  one-cycle completion pulse
- err_out  output  1  qualifies done_out: bus error or abort
- misaligned_out  output  1  qualifies done_out: misaligned trap, no bus transfer
- haddr_out  output  32  HADDR
- htrans_out  output  2  HTRANS: 00 IDLE, 10 NONSEQ only
- hwrite_out  output  1  HWRITE
- hsize_out  output  3  HSIZE = {0, size}
- hburst_out  output  3  constant 000 (SINGLE)
- hwdata_out  output  32  HWDATA
- hready_in  input  1  HREADY
- hresp_in  input  1  HRESP, 1 = ERROR
- hrdata_in  input  32  HRDATA
- lu_size_out  output  2  data-phase load size
- lu_unsigned_out  output  1  data-phase unsigned flag
- lu_offset_out  output  2  data-phase addr[1:0]
- lu_data_out  output  32  hrdata_in, passed through combinationally
- lu_resp_out  output  1  hresp_in, passed through combinationally

Behaviour:
- Reset (synchronous, rst_in=1 at an edge): both pipeline stages invalid; htrans_out=00; haddr_out, hwrite_out, hsize_out, hwdata_out and lu_* registers = 0; done_out, err_out, misaligned_out = 0. Any in-flight transfer is abandoned without completion.
- Two register stages:
  - AP (address phase) drives haddr/htrans/hwrite/hsize.
  - DP (data phase) drives hwdata_out and lu_size/unsigned/offset.
- Aligned request:
  - ready_out = !ap_v || hready_in, forced 0 during error handling.
  - Accept = mem_req_in && ready_out.
  - The accepted request appears on AP outputs at the next cycle with htrans=10.
- Stage advance:
  - Edge with hready_in=1: DP <= AP (if ap_v); AP <= newly accepted request, else htrans=00.
  - Edge with hready_in=0: both stages hold. AHB outputs are stable while stalled.
- Store data in DP, registered from AP:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Completion: done_out=1 in the cycle after the edge where dp_v && hready_in && !hresp_in. Minimum load-to-done latency = 2 cycles after acceptance with zero wait states.
- Load unit interface: the load unit samples lu_data_out in the final data-phase cycle (dp_v && hready_in).
- Misalignment:
  - Applies to a half with addr[0]=1 or a word with addr[1:0]!=0.
  - Accepted only when !ap_v && !dp_v && no error handling; otherwise ready_out=0.
  - No bus transfer is issued. The next cycle gives done_out=1 and misaligned_out=1.
- ERROR response (two-cycle):
  - First cycle (dp_v, hresp_in=1, hready_in=0): at the following edge AP is cancelled (htrans=00) and ready_out is held 0.
  - Second cycle (hresp_in=1, hready_in=1): at the following edge, done_out=1 and err_out=1 for the faulting transfer.
  - If a request was cancelled from AP, the next cycle gives done_out=1 and err_out=1 for that request.
  - Normal acceptance resumes after that.
- Simultaneous events: a new accept in the same cycle as a completion is legal. At most one done_out per cycle. rst_in overrides everything.

Test Plan:
- Load word at 0x100, zero wait states, hrdata=0xDEADBEEF -> htrans=10/hsize=010 one cycle after accept; done_out 2 cycles after accept; lu_data_out=0xDEADBEEF, lu_offset=00.
- Store byte 0xA5 at 0x203 -> hsize=000, haddr=0x203, hwdata=0xA5A5A5A5 in data phase, hwrite=1.
- Load half at 0x302 with 3 wait states (hready=0 x3) -> haddr/hsize/hwdata stable; back-to-back request held in AP; done_out pulses once per transfer, in order.
- Back-to-back loads at 0x0, 0x4, 0x8, hready=1 -> one NONSEQ per cycle; three done_out pulses on consecutive cycles.
- Load at 0x10 gets ERROR while a store at 0x14 sits in AP -> htrans=00 in the second error cycle; done+err for 0x10, then done+err next cycle for 0x14.
- Word load at 0x102 -> no NONSEQ issued; done_out=misaligned_out=1 next cycle. rst_in asserted mid-wait-state -> htrans=00 and all pulses 0 the next cycle.
